// File: rtl/mem_stage.sv
// mem_stage: single-transaction CPU-to-data-memory access stage.
//
// Accepts one load/store request at a time, range-checks the word index
// against MEM_WORDS, drives a one-cycle memory strobe and holds the
// response until the CPU accepts it.
//
// Build option: define MEM_STAGE_BYTE_EN to enable byte accesses (byte
// loads return the addressed lane zero-extended; byte stores run a
// read-modify-write). Without it, reqByte is ignored and every access is
// a word access.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   reqValid/reqReady   request handshake
//   reqWrite, reqByte   1 = store / 1 = byte access
//   reqAddr, reqData    word index (byte address for byte access), store data
//   rspValid/rspReady   response handshake
//   rspData, rspError   load data (0 for stores/errors), out-of-range flag
//   memRead, memWrite   one-cycle memory strobes
//   location, value     memory word index and write data
//   memOut              combinational memory read data
//
// state   | meaning
// IDLE    | ready for a request
// ACCESS  | word access / byte load strobe cycle
// RMW_RD  | byte store: read the containing word
// RMW_WR  | byte store: write the merged word back
// RESP    | response held until rspReady
module mem_stage #(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic        reqByte,
    input  logic [31:0] reqAddr,
    input  logic [31:0] reqData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [31:0] rspData,
    output logic        rspError,
    output logic        memRead,
    output logic        memWrite,
    output logic [31:0] location,
    output logic [31:0] value,
    input  logic [31:0] memOut
);

`ifdef MEM_STAGE_BYTE_EN
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
`else
    typedef enum logic [2:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t      state_q, state_d;
    logic        wr_q, byte_q;
    logic [31:0] addr_q, data_q;
    logic [31:0] rsp_data_q, location_q, value_q;
    logic        rsp_error_q;

    logic        eff_byte;
    logic [31:0] req_index;
    logic        out_of_range;
    logic [31:0] load_word;

`ifdef MEM_STAGE_BYTE_EN
    logic [7:0] lane_byte;

    function automatic logic [31:0] merge_lane(input logic [31:0] w,
                                               input logic [1:0]  lane,
                                               input logic [7:0]  b);
        logic [31:0] r;
        r = w;
        case (lane)
            2'd0: r[7:0]   = b;
            2'd1: r[15:8]  = b;
            2'd2: r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    assign eff_byte = reqByte;

    always_comb begin
        lane_byte = memOut[7:0];
        case (addr_q[1:0])
            2'd1: lane_byte = memOut[15:8];
            2'd2: lane_byte = memOut[23:16];
            2'd3: lane_byte = memOut[31:24];
            default: lane_byte = memOut[7:0];
        endcase
    end

    assign load_word = byte_q ? {24'h0, lane_byte} : memOut;
`else
    assign eff_byte  = 1'b0;
    assign load_word = memOut;
`endif

    // Fields only partly consumed depending on the build option.
    logic unused_req;
    assign unused_req = ^{reqByte, byte_q, addr_q};

    assign req_index    = eff_byte ? {2'b00, reqAddr[31:2]} : reqAddr;
    assign out_of_range = (req_index >= 32'(MEM_WORDS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        reqReady = 1'b0;
        rspValid = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
        case (state_q)
            IDLE: begin
                reqReady = 1'b1;
                if (reqValid) begin
                    if (out_of_range) state_d = RESP;
`ifdef MEM_STAGE_BYTE_EN
                    else if (reqByte && reqWrite) state_d = RMW_RD;
`endif
                    else state_d = ACCESS;
                end
            end
            ACCESS: begin
                memRead  = !wr_q;
                memWrite = wr_q;
                state_d  = RESP;
            end
`ifdef MEM_STAGE_BYTE_EN
            RMW_RD: begin
                memRead = 1'b1;
                state_d = RMW_WR;
            end
            RMW_WR: begin
                memWrite = 1'b1;
                state_d  = RESP;
            end
`endif
            RESP: begin
                rspValid = 1'b1;
                if (rspReady) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // location/value are loaded ahead of the strobe so they are stable for
    // the whole strobe cycle, and otherwise hold their last driven value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= 1'b0;
            byte_q      <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
            location_q  <= '0;
            value_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (reqValid) begin
                        wr_q        <= reqWrite;
                        byte_q      <= eff_byte;
                        addr_q      <= reqAddr;
                        data_q      <= reqData;
                        rsp_data_q  <= '0;
                        rsp_error_q <= out_of_range;
                        if (!out_of_range) begin
                            location_q <= req_index;
                            if (reqWrite && !eff_byte) value_q <= reqData;
                        end
                    end
                end
                ACCESS: begin
                    if (!wr_q) rsp_data_q <= load_word;
                end
`ifdef MEM_STAGE_BYTE_EN
                RMW_RD: begin
                    value_q <= merge_lane(memOut, addr_q[1:0], data_q[7:0]);
                end
`endif
                RESP: begin
                    if (rspReady) rsp_error_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign rspData  = rsp_data_q;
    assign rspError = rsp_error_q;
    assign location = location_q;
    assign value    = value_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reqValid, reqReady, reqWrite, reqByte;
    logic [31:0] reqAddr, reqData;
    logic        rspValid, rspReady, rspError;
    logic [31:0] rspData;
    logic        memRead, memWrite;
    logic [31:0] location, value, memOut;

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;

    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = 8'h0;
    logic [31:0] pre_data = 32'h0;

    always #5 clk = ~clk;

    mem_stage #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqByte(reqByte), .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
        .rspError(rspError), .memRead(memRead), .memWrite(memWrite),
        .location(location), .value(value), .memOut(memOut)
    );

    assign memOut = (location < 32'd256) ? mem[location[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (memWrite && location < 32'd256) mem[location[7:0]] <= value;
        else if (pre_en) mem[pre_addr] <= pre_data;
        if (memRead)  rd_cnt <= rd_cnt + 1;
        if (memWrite) wr_cnt <= wr_cnt + 1;
    end

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk); #1;
        pre_en = 1'b0;
    endtask

    // Returns 1 ns after the accepting edge N.
    task automatic issue(input logic wr, input logic byt,
                         input logic [31:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        reqValid = 1'b1; reqWrite = wr; reqByte = byt;
        reqAddr = addr; reqData = data;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic handshake;
        rspReady = 1'b1;
        @(posedge clk); #1;
        rspReady = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; reqValid = 0; reqWrite = 0; reqByte = 0;
        reqAddr = 0; reqData = 0; rspReady = 0;
        #3;
        checks++;
        if ({memRead, memWrite, rspValid, rspError, rspData, location, value} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rd=%b wr=%b rv=%b re=%b rd=%h loc=%h val=%h required all zero",
                     memRead, memWrite, rspValid, rspError, rspData, location, value);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", reqReady);
        end
    endtask

    task automatic test_word_store_load;
        int w0, r0;
        preload(8'd1, 32'h0);
        w0 = wr_cnt;
        issue(1'b1, 1'b0, 32'd1, 32'h0000_000F);
        @(negedge clk);
        checks++;
        if ({memRead, memWrite} !== 2'b01) begin
            errors++; $display("FAIL st_strobe: got rd/wr=%b%b required 01", memRead, memWrite);
        end
        checks++;
        if (location !== 32'd1 || value !== 32'h0000_000F) begin
            errors++; $display("FAIL st_loc_val: got %h/%h required 00000001/0000000f", location, value);
        end
        checks++;
        if (rspValid !== 1'b0 || reqReady !== 1'b0) begin
            errors++; $display("FAIL st_early: got rv=%b rr=%b required 0 0", rspValid, reqReady);
        end
        @(negedge clk);
        checks++;
        if (memWrite !== 1'b0 || rspValid !== 1'b1 || rspData !== 32'h0 || rspError !== 1'b0) begin
            errors++; $display("FAIL st_resp: got wr=%b rv=%b data=%h err=%b required 0 1 0 0",
                               memWrite, rspValid, rspData, rspError);
        end
        handshake();
        checks++;
        if (wr_cnt - w0 !== 1 || mem[1] !== 32'h0000_000F) begin
            errors++; $display("FAIL st_mem: got writes=%0d mem1=%h required 1 0000000f", wr_cnt - w0, mem[1]);
        end

        r0 = rd_cnt;
        issue(1'b0, 1'b0, 32'd1, 32'hFFFF_FFFF);
        @(negedge clk);
        checks++;
        if ({memRead, memWrite} !== 2'b10 || location !== 32'd1 || rspValid !== 1'b0) begin
            errors++; $display("FAIL ld_strobe: got rd/wr=%b%b loc=%h rv=%b required 10 1 0",
                               memRead, memWrite, location, rspValid);
        end
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'h0000_000F || rspError !== 1'b0) begin
            errors++; $display("FAIL ld_resp: got rv=%b data=%h err=%b required 1 0000000f 0",
                               rspValid, rspData, rspError);
        end
        handshake();
        checks++;
        if (rd_cnt - r0 !== 1) begin
            errors++; $display("FAIL ld_reads: got %0d required 1", rd_cnt - r0);
        end
    endtask

    task automatic test_out_of_range;
        int w0, r0;
        w0 = wr_cnt; r0 = rd_cnt;
        issue(1'b0, 1'b0, 32'd256, 32'h0);
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspError !== 1'b1 || rspData !== 32'h0 || {memRead, memWrite} !== 2'b00) begin
            errors++; $display("FAIL oor_resp: got rv=%b err=%b data=%h rd/wr=%b%b required 1 1 0 00",
                               rspValid, rspError, rspData, memRead, memWrite);
        end
        handshake();
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b0 || rspError !== 1'b0) begin
            errors++; $display("FAIL oor_clear: got rv=%b err=%b required 0 0", rspValid, rspError);
        end
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0123);
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspError !== 1'b1) begin
            errors++; $display("FAIL oor_store: got rv=%b err=%b required 1 1", rspValid, rspError);
        end
        handshake();
        checks++;
        if (wr_cnt !== w0 || rd_cnt !== r0) begin
            errors++; $display("FAIL oor_strobes: got writes=%0d reads=%0d required 0 0", wr_cnt - w0, rd_cnt - r0);
        end
    endtask

    task automatic test_last_word;
        issue(1'b1, 1'b0, 32'd255, 32'hCAFE_F00D);
        @(negedge clk);
        checks++;
        if (memWrite !== 1'b1 || location !== 32'd255 || rspError !== 1'b0) begin
            errors++; $display("FAIL last_word: got wr=%b loc=%h err=%b required 1 000000ff 0",
                               memWrite, location, rspError);
        end
        @(negedge clk);
        handshake();
        checks++;
        if (mem[255] !== 32'hCAFE_F00D) begin
            errors++; $display("FAIL last_word_mem: got %h required cafef00d", mem[255]);
        end
    endtask

    task automatic test_backpressure;
        int w0;
        int bad;
        preload(8'd5, 32'hDEAD_BEEF);
        preload(8'd6, 32'h1234_5678);
        w0 = wr_cnt;
        issue(1'b0, 1'b0, 32'd5, 32'h0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL bp_first: got rv=%b data=%h required 1 deadbeef", rspValid, rspData);
        end
        reqValid = 1'b1; reqWrite = 1'b1; reqByte = 1'b0; reqAddr = 32'd6; reqData = 32'h55;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rspValid !== 1'b1 || rspData !== 32'hDEAD_BEEF || reqReady !== 1'b0 || memWrite !== 1'b0)
                bad++;
        end
        reqValid = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", bad);
        end
        handshake();
        @(negedge clk);
        checks++;
        if (reqReady !== 1'b1 || rspValid !== 1'b0 || memWrite !== 1'b0 || wr_cnt !== w0 || mem[6] !== 32'h1234_5678) begin
            errors++; $display("FAIL bp_ignored: got rr=%b rv=%b wr=%b writes=%0d mem6=%h required 1 0 0 0 12345678",
                               reqReady, rspValid, memWrite, wr_cnt - w0, mem[6]);
        end
    endtask

    task automatic test_reset_mid_access;
        int w0;
        int bad;
        preload(8'd3, 32'h0);
        w0 = wr_cnt;
        issue(1'b1, 1'b0, 32'd3, 32'h77);
        #2;
        checks++;
        if (memWrite !== 1'b1) begin
            errors++; $display("FAIL rst_pre: got wr=%b required 1", memWrite);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({memWrite, memRead, rspValid} !== 3'b000 || location !== 32'h0 || value !== 32'h0) begin
            errors++; $display("FAIL rst_drop: got wr/rd/rv=%b%b%b loc=%h val=%h required 000 0 0",
                               memWrite, memRead, rspValid, location, value);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++; $display("FAIL rst_ready: got %b required 1", reqReady);
        end
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rspValid !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0 || wr_cnt !== w0 || mem[3] !== 32'h0) begin
            errors++; $display("FAIL rst_abort: got rv_cycles=%0d writes=%0d mem3=%h required 0 0 0",
                               bad, wr_cnt - w0, mem[3]);
        end
    endtask

`ifdef MEM_STAGE_BYTE_EN
    task automatic test_byte;
        int w0, r0;
        preload(8'd2, 32'h1122_3344);
        w0 = wr_cnt; r0 = rd_cnt;
        issue(1'b1, 1'b1, 32'd9, 32'hFFFF_FFAA);
        @(negedge clk);
        checks++;
        if ({memRead, memWrite} !== 2'b10 || location !== 32'd2) begin
            errors++; $display("FAIL rmw_rd: got rd/wr=%b%b loc=%h required 10 2", memRead, memWrite, location);
        end
        @(negedge clk);
        checks++;
        if ({memRead, memWrite} !== 2'b01 || value !== 32'h1122_AA44 || rspValid !== 1'b0) begin
            errors++; $display("FAIL rmw_wr: got rd/wr=%b%b val=%h rv=%b required 01 1122aa44 0",
                               memRead, memWrite, value, rspValid);
        end
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'h0) begin
            errors++; $display("FAIL rmw_resp: got rv=%b data=%h required 1 0", rspValid, rspData);
        end
        handshake();
        checks++;
        if (mem[2] !== 32'h1122_AA44 || wr_cnt - w0 !== 1 || rd_cnt - r0 !== 1) begin
            errors++; $display("FAIL rmw_mem: got %h w=%0d r=%0d required 1122aa44 1 1",
                               mem[2], wr_cnt - w0, rd_cnt - r0);
        end
        issue(1'b0, 1'b1, 32'd11, 32'h0);
        @(negedge clk);
        checks++;
        if (memRead !== 1'b1 || location !== 32'd2) begin
            errors++; $display("FAIL bld_strobe: got rd=%b loc=%h required 1 2", memRead, location);
        end
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'h0000_0011) begin
            errors++; $display("FAIL bld_data: got rv=%b data=%h required 1 00000011", rspValid, rspData);
        end
        handshake();
        issue(1'b0, 1'b1, 32'd1024, 32'h0);
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspError !== 1'b1) begin
            errors++; $display("FAIL byte_oor: got rv=%b err=%b required 1 1", rspValid, rspError);
        end
        handshake();
    endtask
`else
    task automatic test_byte_ignored;
        preload(8'd9, 32'h0BAD_F00D);
        issue(1'b0, 1'b1, 32'd9, 32'h0);
        @(negedge clk);
        checks++;
        if (memRead !== 1'b1 || location !== 32'd9) begin
            errors++; $display("FAIL nobyte_loc: got rd=%b loc=%h required 1 9", memRead, location);
        end
        @(negedge clk);
        checks++;
        if (rspValid !== 1'b1 || rspData !== 32'h0BAD_F00D) begin
            errors++; $display("FAIL nobyte_data: got rv=%b data=%h required 1 0badf00d", rspValid, rspData);
        end
        handshake();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_word_store_load();
        test_out_of_range();
        test_last_word();
        test_backpressure();
        test_reset_mid_access();
`ifdef MEM_STAGE_BYTE_EN
        test_byte();
`else
        test_byte_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
